// File: rtl/status_input_ctrl.sv
// Button front end for the LED status block: synchronises and debounces the three
// active-low keys, then turns press edges into start/pause pulses and a step request.
module status_input_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 500000,
  parameter int TICK_DIV    = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] key_n,
  input  logic       auto_en,
  output logic       step_n,
  output logic       start,
  output logic       pause,
  output logic       running,
  output logic [2:0] key_db
);

  localparam int DW = $clog2(DEB_CYCLES) + 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync_q [3];
  logic [2:0]             key_sync;
  logic [DW-1:0]          deb_cnt [3];
  logic [2:0]             key_db_d;
  logic [2:0]             press_q;
  logic [TW-1:0]          tick_cnt;
  logic                   start_next;
  logic                   pause_next;
  logic                   step_req;

  always_comb begin
    key_sync = '0;
    for (int i = 0; i < 3; i++) begin
      key_sync[i] = ~sync_q[i][SYNC_STAGES-1];
    end
  end

  // Synchronisers idle at 1 so a key held through reset must be re-debounced.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i]  <= '1;
        deb_cnt[i] <= '0;
      end
      key_db   <= '0;
      key_db_d <= '0;
      press_q  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], key_n[i]};
        if (key_sync[i] == key_db[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          deb_cnt[i] <= '0;
          key_db[i]  <= key_sync[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
      key_db_d <= key_db;
      press_q  <= key_db & ~key_db_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Start has priority, so a simultaneous pause press is dropped entirely.
  always_comb begin
    state_next = state;
    start_next = 1'b0;
    pause_next = 1'b0;
    if (press_q[0]) begin
      start_next = 1'b1;
      state_next = RUN;
    end else if (press_q[1] && state == RUN) begin
      pause_next = 1'b1;
      state_next = HOLD;
    end
  end

  always_comb begin
    step_req = 1'b0;
    if (auto_en) begin
      step_req = (state == RUN) && (tick_cnt == TICK_MAX);
    end else begin
      step_req = (state != IDLE) && press_q[2];
    end
  end

  // Prescaler freezes in HOLD so the step phase survives a pause/resume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      step_n   <= 1'b1;
      start    <= 1'b0;
      pause    <= 1'b0;
    end else begin
      start  <= start_next;
      pause  <= pause_next;
      step_n <= ~(step_req && step_n);
      if (!auto_en || state == IDLE) begin
        tick_cnt <= '0;
      end else if (state == RUN) begin
        tick_cnt <= (tick_cnt == TICK_MAX) ? '0 : tick_cnt + TW'(1);
      end
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_status_input_ctrl.sv
// Scoreboard bench for status_input_ctrl: stimulus queues expected pulses with their
// cycle numbers, a negedge monitor pops and compares every pulse the DUT emits.
module tb_status_input_ctrl;

  localparam int SYNC_STAGES = 2;
  localparam int DEB_CYCLES  = 4;
  localparam int TICK_DIV    = 5;
  // Inputs change just after an edge, so the sampling edge is one cycle later.
  localparam int LAT = SYNC_STAGES + DEB_CYCLES + 1 + 1;

  localparam int EV_START = 0;
  localparam int EV_PAUSE = 1;
  localparam int EV_STEP  = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] key_n;
  logic       auto_en;
  logic       step_n;
  logic       start;
  logic       pause;
  logic       running;
  logic [2:0] key_db;

  int  cyc = 0;
  int  checks = 0;
  int  passed = 0;
  ev_t exp_q[$];

  status_input_ctrl #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES),
    .TICK_DIV   (TICK_DIV)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .key_n  (key_n),
    .auto_en(auto_en),
    .step_n (step_n),
    .start  (start),
    .pause  (pause),
    .running(running),
    .key_db (key_db)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string ev_name(input int kind);
    case (kind)
      EV_START: return "start";
      EV_PAUSE: return "pause";
      default:  return "step";
    endcase
  endfunction

  task automatic expect_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("[TB] FAIL unexpected_%s: got pulse at cycle %0d, required no pulse", ev_name(kind), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.cyc == cyc) begin
        passed++;
      end else begin
        $display("[TB] FAIL %s_pulse: got %s at cycle %0d, required %s at cycle %0d",
                 ev_name(kind), ev_name(kind), cyc, ev_name(e.kind), e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (start)   check_event(EV_START);
    if (pause)   check_event(EV_PAUSE);
    if (!step_n) check_event(EV_STEP);
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [2:0] keys, input logic auto);
    key_n   = keys;
    auto_en = auto;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int c, r, r2, q, r3, t, u, v, w;
    reset = 1'b1;
    apply_stimulus(3'b111, 1'b1);
    tick(3);
    check_output("rst_step_n", step_n, 1);
    check_output("rst_start", start, 0);
    check_output("rst_pause", pause, 0);
    check_output("rst_running", running, 0);
    check_output("rst_key_db", key_db, 0);
    reset = 1'b0;
    tick(3);

    // Bouncing start key, then a clean press
    for (int i = 0; i < 10; i++) begin
      apply_stimulus({2'b11, 1'(i % 2)}, 1'b1);
      tick(2);
    end
    c = cyc;
    apply_stimulus(3'b110, 1'b1);
    r = c + LAT;
    expect_ev(EV_START, r);
    for (int k = 1; k <= 6; k++) expect_ev(EV_STEP, r + TICK_DIV * k);
    expect_ev(EV_PAUSE, r + 32);
    tick_to(r + 1);
    check_output("run_after_bounce", running, 1);
    check_output("key_db_start", key_db, 3'b001);
    apply_stimulus(3'b111, 1'b1);

    // Pause two cycles after the step at r+30
    tick_to(r + 24);
    apply_stimulus(3'b101, 1'b1);
    tick_to(r + 34);
    check_output("hold_running", running, 0);
    check_output("key_db_pause", key_db, 3'b010);
    apply_stimulus(3'b111, 1'b1);
    tick_to(r + 50);

    // Resume: phase preserved, next step 3 cycles later
    apply_stimulus(3'b110, 1'b1);
    r2 = cyc + LAT;
    expect_ev(EV_START, r2);
    expect_ev(EV_STEP, r2 + 3);
    expect_ev(EV_STEP, r2 + 8);
    tick_to(r2 + 11);
    check_output("resume_running", running, 1);

    // Asynchronous reset mid-run with the start key still held
    #2;
    reset = 1'b1;
    #1;
    check_output("arst_step_n", step_n, 1);
    check_output("arst_running", running, 0);
    check_output("arst_key_db", key_db, 0);
    tick(2);
    reset = 1'b0;
    q = cyc;
    r3 = q + LAT;
    expect_ev(EV_START, r3);
    expect_ev(EV_STEP, r3 + TICK_DIV);
    tick_to(r3 + 1);
    apply_stimulus(3'b111, 1'b1);

    // Dropping auto_en mid-count clears the prescaler
    tick_to(r3 + 7);
    apply_stimulus(3'b111, 1'b0);
    tick_to(r3 + 20);
    t = cyc;
    apply_stimulus(3'b111, 1'b1);
    expect_ev(EV_STEP, t + TICK_DIV);
    expect_ev(EV_STEP, t + 2 * TICK_DIV);
    tick_to(t + 11);
    apply_stimulus(3'b111, 1'b0);

    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);

    // Manual step key in IDLE does nothing
    apply_stimulus(3'b011, 1'b0);
    tick(10);
    check_output("key_db_manual_idle", key_db, 3'b100);
    apply_stimulus(3'b111, 1'b0);
    tick(10);

    // Simultaneous start and pause from IDLE
    u = cyc;
    apply_stimulus(3'b100, 1'b0);
    expect_ev(EV_START, u + LAT);
    tick_to(u + LAT + 1);
    check_output("simul_running", running, 1);
    apply_stimulus(3'b111, 1'b0);
    tick(10);

    v = cyc;
    apply_stimulus(3'b101, 1'b0);
    expect_ev(EV_PAUSE, v + LAT);
    tick_to(v + LAT + 1);
    check_output("manual_hold_running", running, 0);
    apply_stimulus(3'b111, 1'b0);
    tick(10);

    // Manual step in HOLD, held long: a single pulse
    w = cyc;
    apply_stimulus(3'b011, 1'b0);
    expect_ev(EV_STEP, w + LAT);
    tick(50);
    check_output("key_db_manual_hold", key_db, 3'b100);
    apply_stimulus(3'b111, 1'b0);
    tick(12);

    checks++;
    if (exp_q.size() == 0) begin
      passed++;
    end else begin
      $display("[TB] FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
